msk_perm_round_ctrl: RTL and testbench
======================================

# msk_perm_round_ctrl

Round sequencer and masked state register for the d-share Ascon permutation. It loads a masked 320-bit state, then presents the current state and the masked round constant to the round datapath each round; the datapath is constant addition, then substitution, then linear layer. It writes the datapath result back and signals completion after the last round. It sits directly upstream of the constant-addition layer and drives its `state` and `roundcst` inputs.

## Interface
Parameters:
- d, 2, number of shares
- LAT, 1, latency in cycles of the external round datapath from `round_state`/`roundcst` to `round_update` (0 = combinational)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  load `in_state` and begin a permutation; honoured only in IDLE
- nr_sel  in  2  round count select: 00→12, 01→8, 10→6, 11→12 (present only with MSK_PERM_VAR_ROUNDS_EN)
- in_state  in  320*d  masked input state, sampled on the start edge
- round_state  out  320*d  registered masked state fed to the round datapath
- roundcst  out  8*d  masked round constant
- round_update  in  320*d  masked round datapath result
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- out_state  out  320*d  equals `round_state`; valid while `done`=1 and held until the next start

Sharing layout on every bus: share j of bit i is at index i*d+j.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 → state register <= `in_state`; rnd <= 12−nr; cnt <= 0; go to RUN.
- RUN:
  - cnt increments every cycle.
  - When cnt==LAT: state register <= `round_update`; cnt <= 0; rnd <= rnd+1.
  - If rnd was 11 at that update, go to DONE; otherwise stay in RUN.
- DONE: go to IDLE after one cycle.
- Round constant for index r (4 bits): c = {(15−r)[3:0], r[3:0]}.
  - Values for r = 0..11: F0, E1, D2, C3, B4, A5, 96, 87, 78, 69, 5A, 4B.
  - Encoding: share 0 carries bit c[i] at index i*d; all other shares are 0. This is public-constant sharing; no randomness is used.
- `roundcst` is all-zero outside RUN.
- `start` in RUN or DONE is ignored and does not disturb the run.
- `in_state` is don't-care except on the start edge.
- `round_update` is sampled only when cnt==LAT.
- nr_sel is sampled only on the start edge. Changes during RUN have no effect.

## Timing
- Reset values:
  - FSM IDLE; rnd=0, cnt=0
  - state register all-zero, so `round_state`/`out_state` are 0
  - `roundcst` 0, `busy` 0, `done` 0
- Each round lasts LAT+1 cycles. `round_state` and `roundcst` are stable for the whole round.
- `done` rises exactly nr*(LAT+1) cycles after the start edge. Example: LAT=1, nr=12 gives 24 cycles.
- `busy` deasserts in the same cycle `done` asserts.
- The earliest accepted restart is the first IDLE cycle, one cycle after `done`.
- Reset asserted mid-run returns immediately to reset values. No `done` pulse is emitted and no partial state is reported.

## Configuration
- MSK_PERM_VAR_ROUNDS_EN defined:
  - `nr_sel` port exists.
  - Round counts 12/8/6 are selectable.
  - The first constant index is 12−nr.
- Not defined:
  - `nr_sel` port is absent.
  - Always 12 rounds starting at r=0, i.e. constant F0.
  - The selection logic is removed.

## Test plan
- Reset while RUN, LAT=1 → all outputs return to 0 asynchronously; the next start completes a fresh full run.
- d=2, LAT=1, start with a random masked state; bench models the round datapath as an XOR-recombined Ascon round → `done` at cycle 24; unmasked `out_state` equals the Ascon p12 reference; `roundcst` share 0 steps F0…4B with share 1 always 0.
- MSK_PERM_VAR_ROUNDS_EN, nr_sel=10 → 6 rounds, constants 96, 87, 78, 69, 5A, 4B; `done` at cycle 12. nr_sel=01 → first constant B4, `done` at cycle 16.
- LAT=0, nr=12 → `done` at cycle 12; `roundcst` changes every cycle.
- `start` pulsed at cycles 5 and 23 of a run (LAT=1) → ignored, single `done` at 24. `start` at the first IDLE cycle after `done` → new run accepted; `out_state` held until then.
- LAT=3, d=3 → each constant held 4 cycles; `round_update` changes at off-cycles have no effect on the result.

Source files
------------

// File: rtl/msk_perm_round_ctrl.sv
// Round sequencer and masked state register for the d-share Ascon permutation.
// Build option: MSK_PERM_VAR_ROUNDS_EN adds nr_sel (12/8/6 rounds); otherwise always 12.
module msk_perm_round_ctrl #(
    parameter int d   = 2,
    parameter int LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef MSK_PERM_VAR_ROUNDS_EN
    input  logic [1:0]         nr_sel,
`endif
    input  logic [320*d-1:0]   in_state,
    output logic [320*d-1:0]   round_state,
    output logic [8*d-1:0]     roundcst,
    input  logic [320*d-1:0]   round_update,
    output logic               busy,
    output logic               done,
    output logic [320*d-1:0]   out_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int            CW       = $clog2(LAT + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(LAT);

    logic [1:0]         fsm;
    logic [3:0]         rnd;
    logic [3:0]         rnd_first;
    logic [CW-1:0]      cnt;
    logic [320*d-1:0]   st;
    logic [7:0]         cst;

    // Shorter runs use the tail of the 12-constant schedule.
`ifdef MSK_PERM_VAR_ROUNDS_EN
    always_comb begin
        case (nr_sel)
            2'b01:   rnd_first = 4'd4;
            2'b10:   rnd_first = 4'd6;
            default: rnd_first = 4'd0;
        endcase
    end
`else
    assign rnd_first = 4'd0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm <= IDLE;
            rnd <= 4'd0;
            cnt <= '0;
            st  <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (start) begin
                        st  <= in_state;
                        rnd <= rnd_first;
                        cnt <= '0;
                        fsm <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == CNT_LAST) begin
                        st  <= round_update;
                        cnt <= '0;
                        rnd <= rnd + 4'd1;
                        if (rnd == 4'd11) fsm <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    fsm <= IDLE;
                default: fsm <= IDLE;
            endcase
        end
    end

    assign cst = {~rnd, rnd};

    // Public constant: share 0 carries it, other shares stay zero.
    for (genvar i = 0; i < 8; i++) begin : g_cst
        for (genvar j = 0; j < d; j++) begin : g_sh
            if (j == 0) begin : g_s0
                assign roundcst[i*d+j] = (fsm == RUN) & cst[i];
            end else begin : g_sn
                assign roundcst[i*d+j] = 1'b0;
            end
        end
    end

    assign round_state = st;
    assign out_state   = st;
    assign busy        = (fsm == RUN);
    assign done        = (fsm == DONE);

endmodule

// File: tb/tb_msk_perm_round_ctrl.sv
// Directed bench for msk_perm_round_ctrl: three instances (d2/LAT1, d2/LAT0, d3/LAT3)
// driven by an XOR-recombined Ascon round model.
module tb_msk_perm_round_ctrl;

    typedef struct {
        logic [3:0] r;
        logic [7:0] cst;
    } cst_t;

    cst_t tbl[12];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start0 = 1'b0, start1 = 1'b0, start3 = 1'b0;
    logic [639:0] in0 = '0, in1 = '0, rs0, rs1, ru0, ru1, os0, os1;
    logic [959:0] in3 = '0, rs3, ru3, os3;
    logic [15:0]  rc0, rc1;
    logic [23:0]  rc3;
    logic         busy0, busy1, busy3, done0, done1, done3;
    logic [959:0] m0, m1, m3, t0, t1, t3;
    logic         good3 = 1'b1;
`ifdef MSK_PERM_VAR_ROUNDS_EN
    logic [1:0]   nr_sel0 = 2'b00, nr_sel1 = 2'b00, nr_sel3 = 2'b00;
`endif

    msk_perm_round_ctrl #(.d(2), .LAT(1)) u0 (
        .clk(clk), .rst(rst), .start(start0),
`ifdef MSK_PERM_VAR_ROUNDS_EN
        .nr_sel(nr_sel0),
`endif
        .in_state(in0), .round_state(rs0), .roundcst(rc0), .round_update(ru0),
        .busy(busy0), .done(done0), .out_state(os0));

    msk_perm_round_ctrl #(.d(2), .LAT(0)) u1 (
        .clk(clk), .rst(rst), .start(start1),
`ifdef MSK_PERM_VAR_ROUNDS_EN
        .nr_sel(nr_sel1),
`endif
        .in_state(in1), .round_state(rs1), .roundcst(rc1), .round_update(ru1),
        .busy(busy1), .done(done1), .out_state(os1));

    msk_perm_round_ctrl #(.d(3), .LAT(3)) u3 (
        .clk(clk), .rst(rst), .start(start3),
`ifdef MSK_PERM_VAR_ROUNDS_EN
        .nr_sel(nr_sel3),
`endif
        .in_state(in3), .round_state(rs3), .roundcst(rc3), .round_update(ru3),
        .busy(busy3), .done(done3), .out_state(os3));

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [7:0] c);
        logic [63:0] x0, x1, x2, x3, x4, a0, a1, a2, a3, a4;
        x0 = s[63:0]; x1 = s[127:64]; x2 = s[191:128]; x3 = s[255:192]; x4 = s[319:256];
        x2 = x2 ^ {56'b0, c};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        a0 = ~x0 & x1; a1 = ~x1 & x2; a2 = ~x2 & x3; a3 = ~x3 & x4; a4 = ~x4 & x0;
        x0 = x0 ^ a1; x1 = x1 ^ a2; x2 = x2 ^ a3; x3 = x3 ^ a4; x4 = x4 ^ a0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x4, x3, x2, x1, x0};
    endfunction

    function automatic logic [319:0] unmask(input logic [959:0] b, input int nd);
        logic [319:0] x;
        x = '0;
        for (int i = 0; i < 320; i++)
            for (int j = 0; j < nd; j++) x[i] = x[i] ^ b[i*nd+j];
        return x;
    endfunction

    function automatic logic [959:0] mask(input logic [319:0] x, input logic [959:0] m, input int nd);
        logic [959:0] b;
        logic s;
        b = '0;
        for (int i = 0; i < 320; i++) begin
            s = x[i];
            for (int j = 1; j < nd; j++) begin
                b[i*nd+j] = m[i*nd+j];
                s = s ^ m[i*nd+j];
            end
            b[i*nd] = s;
        end
        return b;
    endfunction

    function automatic logic [7:0] rc_un(input logic [23:0] rc, input int nd);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < nd; j++) c[i] = c[i] ^ rc[i*nd+j];
        return c;
    endfunction

    function automatic logic [23:0] expand(input logic [7:0] c, input int nd);
        logic [23:0] e;
        e = '0;
        for (int i = 0; i < 8; i++) e[i*nd] = c[i];
        return e;
    endfunction

    function automatic logic [959:0] rnd960();
        logic [959:0] r;
        for (int i = 0; i < 30; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [319:0] p_ref(input logic [319:0] s, input int first);
        logic [319:0] x;
        x = s;
        for (int r = first; r < 12; r++) x = ascon_round(x, tbl[r].cst);
        return x;
    endfunction

    // Round datapath models; instance 3 is fed garbage except in the sampling cycle.
    always_comb begin
        t0  = mask(ascon_round(unmask({320'b0, rs0}, 2), rc_un({8'b0, rc0}, 2)), m0, 2);
        ru0 = t0[639:0];
        t1  = mask(ascon_round(unmask({320'b0, rs1}, 2), rc_un({8'b0, rc1}, 2)), m1, 2);
        ru1 = t1[639:0];
        t3  = mask(ascon_round(unmask(rs3, 3), rc_un(rc3, 3)), m3, 3);
        ru3 = good3 ? t3 : ~t3;
    end

    function automatic logic [959:0] get_rs(input int inst);
        case (inst)
            0:       return {320'b0, rs0};
            1:       return {320'b0, rs1};
            default: return rs3;
        endcase
    endfunction

    function automatic logic [959:0] get_os(input int inst);
        case (inst)
            0:       return {320'b0, os0};
            1:       return {320'b0, os1};
            default: return os3;
        endcase
    endfunction

    function automatic logic [23:0] get_rc(input int inst);
        case (inst)
            0:       return {8'b0, rc0};
            1:       return {8'b0, rc1};
            default: return rc3;
        endcase
    endfunction

    function automatic logic get_busy(input int inst);
        return (inst == 0) ? busy0 : (inst == 1) ? busy1 : busy3;
    endfunction

    function automatic logic get_done(input int inst);
        return (inst == 0) ? done0 : (inst == 1) ? done1 : done3;
    endfunction

    task automatic chk(input string nm, input logic [959:0] act, input logic [959:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h (low 128 bits)", nm, act[127:0], exp[127:0]);
        end
    endtask

    task automatic set_start(input int inst, input logic v);
        case (inst)
            0:       start0 = v;
            1:       start1 = v;
            default: start3 = v;
        endcase
    endtask

    // Launch a run on one instance, check per-cycle constants, done timing and result.
    // rst_k >= 0 asserts reset asynchronously in that run cycle instead.
    task automatic run(input int inst, input int nr, input bit pulses, input int rst_k,
                       output logic [319:0] ref_out);
        int nd, l1, k, dcyc, idx;
        logic [319:0] x;
        logic [959:0] b;
        nd = (inst == 2) ? 3 : 2;
        l1 = (inst == 0) ? 2 : (inst == 1) ? 1 : 4;
        x  = rnd960();
        b  = mask(x, rnd960(), nd);
        ref_out = p_ref(x, 12 - nr);
        case (inst)
            0:       in0 = b[639:0];
            1:       in1 = b[639:0];
            default: in3 = b;
        endcase
`ifdef MSK_PERM_VAR_ROUNDS_EN
        if (inst == 0) nr_sel0 = (nr == 8) ? 2'b01 : (nr == 6) ? 2'b10 : 2'b00;
`endif
        good3 = 1'b0;
        set_start(inst, 1'b1);
        @(posedge clk); #1;
        set_start(inst, 1'b0);
        case (inst)
            0:       in0 = ~in0;
            1:       in1 = ~in1;
            default: in3 = ~in3;
        endcase
        k = 0;
        dcyc = -1;
        while (k < nr * l1 + 8) begin
            if (get_done(inst)) begin
                dcyc = k;
                break;
            end
            if (k == rst_k) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_round_state", get_rs(inst), '0);
                chk("rst_out_state", get_os(inst), '0);
                chk("rst_roundcst", {936'b0, get_rc(inst)}, '0);
                chk("rst_busy", {959'b0, get_busy(inst)}, '0);
                chk("rst_done", {959'b0, get_done(inst)}, '0);
                #1 rst = 1'b0;
                @(posedge clk); #1;
                chk("rst_stays_idle", {959'b0, get_busy(inst) | get_done(inst)}, '0);
                return;
            end
            chk("busy_in_run", {959'b0, get_busy(inst)}, {959'b0, 1'b1});
            idx = 12 - nr + k / l1;
            if (idx < 12)
                chk($sformatf("roundcst_k%0d", k), {936'b0, get_rc(inst)},
                    {936'b0, expand(tbl[idx].cst, nd)});
            if (inst == 2) good3 = ((k % 4) == 3);
            if (inst == 0) start0 = pulses && (k == 5 || k == 23);
`ifdef MSK_PERM_VAR_ROUNDS_EN
            if (inst == 0 && k == 2) nr_sel0 = ~nr_sel0;
`endif
            @(posedge clk); #1;
            k++;
        end
        start0 = 1'b0;
        good3  = 1'b1;
        chk("done_cycle", 960'(dcyc), 960'(nr * l1));
        chk("busy_at_done", {959'b0, get_busy(inst)}, '0);
        chk("roundcst_at_done", {936'b0, get_rc(inst)}, '0);
        chk("result", {640'b0, unmask(get_os(inst), nd)}, {640'b0, ref_out});
        chk("out_eq_round_state", get_os(inst), get_rs(inst));
        @(posedge clk); #1;
        chk("done_single_pulse", {959'b0, get_done(inst) | get_busy(inst)}, '0);
    endtask

    initial begin
        logic [319:0] r;
        tbl[0]  = '{4'd0,  8'hF0}; tbl[1]  = '{4'd1,  8'hE1}; tbl[2]  = '{4'd2,  8'hD2};
        tbl[3]  = '{4'd3,  8'hC3}; tbl[4]  = '{4'd4,  8'hB4}; tbl[5]  = '{4'd5,  8'hA5};
        tbl[6]  = '{4'd6,  8'h96}; tbl[7]  = '{4'd7,  8'h87}; tbl[8]  = '{4'd8,  8'h78};
        tbl[9]  = '{4'd9,  8'h69}; tbl[10] = '{4'd10, 8'h5A}; tbl[11] = '{4'd11, 8'h4B};
        m0 = rnd960(); m1 = rnd960(); m3 = rnd960();

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_round_state", get_rs(i), '0);
            chk("reset_roundcst", {936'b0, get_rc(i)}, '0);
            chk("reset_busy_done", {958'b0, get_busy(i), get_done(i)}, '0);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Full 12-round run with stray start pulses, then restart in the first IDLE cycle.
        run(0, 12, 1'b1, -1, r);
        chk("hold_first_idle", {640'b0, unmask({320'b0, os0}, 2)}, {640'b0, r});
        run(0, 12, 1'b0, 9, r);
        run(0, 12, 1'b0, -1, r);
        repeat (3) begin
            @(posedge clk); #1;
            chk("hold_idle", {640'b0, unmask({320'b0, os0}, 2)}, {640'b0, r});
        end

        run(1, 12, 1'b0, -1, r);
        run(2, 12, 1'b0, -1, r);
`ifdef MSK_PERM_VAR_ROUNDS_EN
        run(0, 6, 1'b0, -1, r);
        run(0, 8, 1'b0, -1, r);
        run(0, 12, 1'b0, -1, r);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
